// File: rtl/clk_div_pkg.sv
// Shared types and helpers for the clock divider controller.
//   state_e     : controller FSM states
//   CntWDefault : default counter / divide-value width
//   clamp_div() : maps a requested half-period of 0 onto 1
package clk_div_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StStop
  } state_e;

  localparam int unsigned CntWDefault = 8;

  // A half-period of zero clk cycles is meaningless; the shortest legal one is 1.
  function automatic int unsigned clamp_div(input int unsigned v);
    return (v == 32'd0) ? 32'd1 : v;
  endfunction

endpackage

// File: rtl/clk_div_ctrl_if.sv
// Control / status bundle between the config registers and the divider controller.
//   en         : run request (level)
//   div_val    : requested half-period length in clk cycles
//   div_load   : div_val valid
//   div_ready  : controller can accept div_val
//   clk_div    : divided clock
//   tick       : one-cycle pulse on every clk_div transition
//   busy       : controller not idle
//   period_cnt : count of clk_div falling edges (only with CLK_DIV_CTRL_PERIOD_CNT_EN)
// master = register/config side, slave = controller side.
interface clk_div_ctrl_if
  import clk_div_pkg::*;
#(
  parameter int unsigned CNT_W = CntWDefault
) ();

  logic             en;
  logic [CNT_W-1:0] div_val;
  logic             div_load;
  logic             div_ready;
  logic             clk_div;
  logic             tick;
  logic             busy;
`ifdef CLK_DIV_CTRL_PERIOD_CNT_EN
  logic [15:0]      period_cnt;

  modport master (
    output en, div_val, div_load,
    input  div_ready, clk_div, tick, busy, period_cnt
  );

  modport slave (
    input  en, div_val, div_load,
    output div_ready, clk_div, tick, busy, period_cnt
  );
`else
  modport master (
    output en, div_val, div_load,
    input  div_ready, clk_div, tick, busy
  );

  modport slave (
    input  en, div_val, div_load,
    output div_ready, clk_div, tick, busy
  );
`endif

endinterface

// File: rtl/clk_div_core.sv
// Counting datapath of the clock divider.
//   clk, rst_n : system clock, asynchronous active-low reset
//   run        : count this cycle (controller in RUN or STOP)
//   clr        : controller leaves for IDLE this cycle; restart counter from 0
//   load_en    : write load_val into the active half-period register
//   load_val   : new half-period length (already clamped, >= 1)
//   tc         : terminal count this cycle (combinational)
//   clk_div    : divided clock, registered
//   tick       : registered pulse following every terminal count
//   period_cnt : clk_div falling-edge counter (only with CLK_DIV_CTRL_PERIOD_CNT_EN)
module clk_div_core #(
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned DEFAULT_DIV = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic             clr,
  input  logic             load_en,
  input  logic [CNT_W-1:0] load_val,
  output logic             tc,
  output logic             clk_div,
`ifdef CLK_DIV_CTRL_PERIOD_CNT_EN
  output logic [15:0]      period_cnt,
`endif
  output logic             tick
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] active_q;
  logic             clk_div_q;
  logic             tick_q;

  assign tc = run && (cnt_q == (active_q - CNT_W'(1)));

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (!run || tc || clr) begin
      cnt_d = '0;
    end
  end

  // active_q only changes at a terminal count or while idle, i.e. whenever the
  // counter restarts from 0, so the compare never overshoots a shorter ratio.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      active_q  <= CNT_W'(DEFAULT_DIV);
      clk_div_q <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tc;
      if (load_en) begin
        active_q <= load_val;
      end
      if (tc) begin
        clk_div_q <= ~clk_div_q;
      end
    end
  end

`ifdef CLK_DIV_CTRL_PERIOD_CNT_EN
  logic [15:0] period_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      period_q <= 16'd0;
    end else if (tc && clk_div_q) begin
      period_q <= period_q + 16'd1;
    end
  end

  assign period_cnt = period_q;
`endif

  assign clk_div = clk_div_q;
  assign tick    = tick_q;

endmodule

// File: rtl/clk_div_ctrl.sv
// Run-time controller for the programmable clock divider: starts/stops clk_div
// without runt phases and accepts new half-period lengths over a valid/ready
// handshake, applying them only at half-period boundaries.
//   clk, rst_n : system clock, asynchronous active-low reset
//   bus        : clk_div_ctrl_if slave (en, div_val/div_load/div_ready,
//                clk_div, tick, busy, optional period_cnt)
// Build option: define CLK_DIV_CTRL_PERIOD_CNT_EN to add the period_cnt output.
module clk_div_ctrl
  import clk_div_pkg::*;
#(
  parameter int unsigned CNT_W       = CntWDefault,
  parameter int unsigned DEFAULT_DIV = 10
) (
  input logic           clk,
  input logic           rst_n,
  clk_div_ctrl_if.slave bus
);

  state_e           state_q, state_d;
  logic             pending_q, pending_d;
  logic [CNT_W-1:0] pend_div_q, pend_div_d;

  logic             run;
  logic             clr;
  logic             tc;
  logic             clk_div_cur;
  logic             clk_next;
  logic             xfer;
  logic             load_en;
  logic [CNT_W-1:0] load_val;
  logic [CNT_W-1:0] req_div;

  assign run     = (state_q != StIdle);
  assign req_div = CNT_W'(clamp_div(32'(bus.div_val)));
  assign xfer    = bus.div_load && !pending_q;

  // The en rule in RUN looks at clk_div after any toggle from this cycle's TC.
  always_comb begin
    state_d  = state_q;
    clk_next = tc ? ~clk_div_cur : clk_div_cur;
    unique case (state_q)
      StIdle: begin
        if (bus.en) state_d = StRun;
      end
      StRun: begin
        if (!bus.en) state_d = clk_next ? StStop : StIdle;
      end
      StStop: begin
        // Re-enable wins over the final fall: at TC the output drops and counting
        // simply continues, giving an ordinary low half-period.
        if (bus.en) begin
          state_d = StRun;
        end else if (tc) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign clr = run && (state_d == StIdle);

  // Ratio routing: idle loads go straight through; while running a value is
  // parked in pend_div until the next half-period boundary (TC or entry to IDLE).
  always_comb begin
    load_en    = 1'b0;
    load_val   = req_div;
    pending_d  = pending_q;
    pend_div_d = pend_div_q;
    if (!run) begin
      load_en = xfer;
    end else if (tc || clr) begin
      pending_d = 1'b0;
      if (pending_q) begin
        load_en  = 1'b1;
        load_val = pend_div_q;
      end else begin
        load_en = xfer;
      end
    end else if (xfer) begin
      pending_d  = 1'b1;
      pend_div_d = req_div;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      pending_q  <= 1'b0;
      pend_div_q <= CNT_W'(DEFAULT_DIV);
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      pend_div_q <= pend_div_d;
    end
  end

  clk_div_core #(
    .CNT_W       (CNT_W),
    .DEFAULT_DIV (DEFAULT_DIV)
  ) u_core (
    .clk        (clk),
    .rst_n      (rst_n),
    .run        (run),
    .clr        (clr),
    .load_en    (load_en),
    .load_val   (load_val),
    .tc         (tc),
    .clk_div    (clk_div_cur),
`ifdef CLK_DIV_CTRL_PERIOD_CNT_EN
    .period_cnt (bus.period_cnt),
`endif
    .tick       (bus.tick)
  );

  assign bus.clk_div   = clk_div_cur;
  assign bus.div_ready = ~pending_q;
  assign bus.busy      = run;

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Self-checking bench for clk_div_ctrl: directed corner sequences, a table of
// half-period lengths, and randomized traffic against a countdown reference model.
module tb_clk_div_ctrl;

  localparam int unsigned CNT_W = 8;
  localparam int unsigned DEF   = 10;
  localparam int          TMO   = 600;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  clk_div_ctrl_if #(.CNT_W(CNT_W)) bus ();

  clk_div_ctrl #(
    .CNT_W       (CNT_W),
    .DEFAULT_DIV (DEF)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  task automatic check(input string name, input int act, input int exp);
    chk_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  function automatic int sample(input int sel);
    case (sel)
      0:       return int'(bus.clk_div);
      1:       return int'(bus.busy);
      default: return int'(bus.div_ready);
    endcase
  endfunction

  // Counts negedges until the selected output equals val; gives up after max.
  task automatic wait_for(input int sel, input int val, input int max, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((sample(sel) != val) && (n < max));
  endtask

  task automatic do_reset();
    bus.en       = 1'b0;
    bus.div_load = 1'b0;
    bus.div_val  = '0;
    rst_n        = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic load_idle(input int val);
    bus.div_load = 1'b1;
    bus.div_val  = CNT_W'(val);
    @(negedge clk);
    bus.div_load = 1'b0;
  endtask

  // Reference model: remaining cycles in the current half-period, counted down.
  int m_mode;   // 0 idle, 1 run, 2 stop
  int m_left;
  int m_level;
  int m_div;
  int m_pend;   // -1 when nothing is parked
  int m_tick;
  int m_pcnt;

  task automatic model_reset();
    m_mode = 0; m_left = 0; m_level = 0; m_div = DEF; m_pend = -1; m_tick = 0; m_pcnt = 0;
  endtask

  task automatic model_step(input int en, input int ld, input int val);
    int v, nmode, nlevel;
    bit flip, xfer;
    v      = (val == 0) ? 1 : val;
    flip   = (m_mode != 0) && (m_left == 1);
    xfer   = (ld != 0) && (m_pend < 0);
    nlevel = flip ? 1 - m_level : m_level;
    case (m_mode)
      0:       nmode = (en != 0) ? 1 : 0;
      1:       nmode = (en != 0) ? 1 : ((nlevel != 0) ? 2 : 0);
      default: nmode = (en != 0) ? 1 : (flip ? 0 : 2);
    endcase
    if (m_mode == 0) begin
      if (xfer) m_div = v;
    end else if (flip || nmode == 0) begin
      if (m_pend >= 0) begin
        m_div  = m_pend;
        m_pend = -1;
      end else if (xfer) begin
        m_div = v;
      end
    end else if (xfer) begin
      m_pend = v;
    end
    if (nmode != 0) begin
      if (m_mode == 0 || flip) m_left = m_div;
      else m_left = m_left - 1;
    end
    if (flip && m_level != 0) m_pcnt = (m_pcnt + 1) % 65536;
    m_tick  = flip ? 1 : 0;
    m_level = nlevel;
    m_mode  = nmode;
  endtask

  typedef struct {
    int val;
    int half;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, ticks;
    int en_r, ld_r, val_r;

    vecs[0] = '{val: 0,   half: 1};
    vecs[1] = '{val: 1,   half: 1};
    vecs[2] = '{val: 2,   half: 2};
    vecs[3] = '{val: 5,   half: 5};
    vecs[4] = '{val: 17,  half: 17};
    vecs[5] = '{val: 255, half: 255};

    bus.en = 1'b0; bus.div_load = 1'b0; bus.div_val = '0;
    #2 rst_n = 1'b0;
    #1;
    check("rst clk_div", int'(bus.clk_div), 0);
    check("rst tick", int'(bus.tick), 0);
    check("rst busy", int'(bus.busy), 0);
    check("rst ready", int'(bus.div_ready), 1);
`ifdef CLK_DIV_CTRL_PERIOD_CNT_EN
    check("rst period_cnt", int'(bus.period_cnt), 0);
`endif
    do_reset();

    // T1: default ratio, first rise DEF cycles after RUN entry, period 2*DEF.
    bus.en = 1'b1;
    wait_for(1, 1, TMO, n); check("t1 busy", n, 1);
    wait_for(0, 1, TMO, n); check("t1 first rise", n, DEF);
    check("t1 tick at rise", int'(bus.tick), 1);
    ticks = 0;
    for (int i = 0; i < 2 * DEF; i++) begin
      @(negedge clk);
      ticks += int'(bus.tick);
    end
    check("t1 ticks per period", ticks, 2);
    check("t1 level after period", int'(bus.clk_div), 1);

    // T2: load 4 at counter 3 of a 10-cycle high phase.
    repeat (3) @(negedge clk);
    bus.div_load = 1'b1; bus.div_val = 8'd4;
    @(negedge clk);
    bus.div_load = 1'b0;
    check("t2 ready low", int'(bus.div_ready), 0);
    wait_for(0, 0, TMO, n); check("t2 old half rest", n, 6);
    check("t2 ready back", int'(bus.div_ready), 1);
    wait_for(0, 1, TMO, n); check("t2 new half lo", n, 4);
    wait_for(0, 0, TMO, n); check("t2 new half hi", n, 4);
    bus.en = 1'b0;
    wait_for(1, 0, TMO, n); check("t2 idle from low", n, 1);

    // T3: stop at counter 3 of a high phase; TC six cycles on, visible one later.
    load_idle(10);
    bus.en = 1'b1;
    wait_for(1, 1, TMO, n); check("t3 busy", n, 1);
    wait_for(0, 1, TMO, n); check("t3 rise", n, 10);
    repeat (3) @(negedge clk);
    bus.en = 1'b0;
    wait_for(0, 0, TMO, n); check("t3 fall", n, 7);
    check("t3 busy at fall", int'(bus.busy), 0);
    repeat (5) @(negedge clk);
    check("t3 stays low", int'(bus.clk_div), 0);
    check("t3 stays idle", int'(bus.busy), 0);

    // T4: zero clamps to 1, output toggles every cycle.
    load_idle(0);
    bus.en = 1'b1;
    wait_for(1, 1, TMO, n); check("t4 busy", n, 1);
    wait_for(0, 1, TMO, n); check("t4 rise", n, 1);
    wait_for(0, 0, TMO, n); check("t4 fall", n, 1);
    wait_for(0, 1, TMO, n); check("t4 rise2", n, 1);
    bus.en = 1'b0;
    wait_for(1, 0, TMO, n);
    check("t4 idle", int'(bus.busy), 0);
    check("t4 idle low", int'(bus.clk_div), 0);

    // T5: load on the TC cycle takes effect for the very next half-period.
    load_idle(10);
    bus.en = 1'b1;
    wait_for(1, 1, TMO, n);
    wait_for(0, 1, TMO, n); check("t5 rise", n, 10);
    repeat (9) @(negedge clk);
    check("t5 ready at tc", int'(bus.div_ready), 1);
    bus.div_load = 1'b1; bus.div_val = 8'd3;
    @(negedge clk);
    bus.div_load = 1'b0;
    check("t5 fall on time", int'(bus.clk_div), 0);
    check("t5 ready kept", int'(bus.div_ready), 1);
    wait_for(0, 1, TMO, n); check("t5 next half", n, 3);
    check("t5 ready still", int'(bus.div_ready), 1);

    // T6: reset while stopping with a parked ratio.
    bus.en = 1'b0;
    bus.div_load = 1'b1; bus.div_val = 8'd7;
    @(negedge clk);
    bus.div_load = 1'b0;
    check("t6 stop busy", int'(bus.busy), 1);
    check("t6 pending", int'(bus.div_ready), 0);
    #1 rst_n = 1'b0;
    #1;
    check("t6 rst clk_div", int'(bus.clk_div), 0);
    check("t6 rst tick", int'(bus.tick), 0);
    check("t6 rst busy", int'(bus.busy), 0);
    check("t6 rst ready", int'(bus.div_ready), 1);
`ifdef CLK_DIV_CTRL_PERIOD_CNT_EN
    check("t6 rst period_cnt", int'(bus.period_cnt), 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    bus.en = 1'b1;
    wait_for(1, 1, TMO, n); check("t6 busy", n, 1);
    wait_for(0, 1, TMO, n); check("t6 default ratio", n, DEF);

    // Table: idle load then one full period per record.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      load_idle(vecs[i].val);
      bus.en = 1'b1;
      wait_for(1, 1, TMO, n); check("vec busy", n, 1);
      wait_for(0, 1, TMO, n); check("vec rise", n, vecs[i].half);
      check("vec tick", int'(bus.tick), 1);
      wait_for(0, 0, TMO, n); check("vec fall", n, vecs[i].half);
      bus.en = 1'b0;
      wait_for(1, 0, TMO, n);
      check("vec idle", int'(bus.busy), 0);
      check("vec idle low", int'(bus.clk_div), 0);
    end

    // Randomized traffic against the model.
    do_reset();
    model_reset();
    en_r = 0;
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 15) == 0) en_r = 1 - en_r;
      ld_r  = ($urandom_range(0, 3) == 0) ? 1 : 0;
      val_r = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 24)) :
                                            int'($urandom_range(0, 6));
      bus.en       = en_r[0];
      bus.div_load = ld_r[0];
      bus.div_val  = CNT_W'(val_r);
      model_step(en_r, ld_r, val_r);
      @(negedge clk);
      check("rnd clk_div", int'(bus.clk_div), m_level);
      check("rnd tick", int'(bus.tick), m_tick);
      check("rnd busy", int'(bus.busy), (m_mode != 0) ? 1 : 0);
      check("rnd ready", int'(bus.div_ready), (m_pend < 0) ? 1 : 0);
`ifdef CLK_DIV_CTRL_PERIOD_CNT_EN
      check("rnd period_cnt", int'(bus.period_cnt), m_pcnt);
`endif
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
